// File: rtl/soc_trace_arbiter_pkg.sv
// soc_trace_arbiter_pkg: trace record type and field widths for soc_trace_arbiter.
// The timestamp field exists only when SOC_TRACE_ARBITER_TIMESTAMP_EN is defined.
package soc_trace_arbiter_pkg;
    localparam int PC_W    = 32;
    localparam int INSN_W  = 32;
    localparam int WBREG_W = 5;
    localparam int DATA_W  = 32;
    localparam int TS_W    = 32;
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSN_W-1:0]  insn;
        logic               wben;
        logic [WBREG_W-1:0] wbreg;
        logic [DATA_W-1:0]  wbdata;
`ifdef SOC_TRACE_ARBITER_TIMESTAMP_EN
        logic [TS_W-1:0]    timestamp;
`endif
    } trace_rec_t;
endpackage

// File: rtl/soc_trace_rr_arbiter.sv
// soc_trace_rr_arbiter: combinational round-robin pick of the first request after i_last.
module soc_trace_rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_last,
    output logic [N-1:0]    o_gnt,
    output logic [ID_W-1:0] o_idx
);
    logic [ID_W-1:0] w_j;
    logic            w_found;
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 1; k <= N; k++) begin
            w_j = ID_W'((int'(i_last) + k) % N);
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end
endmodule

// File: rtl/soc_trace_arbiter.sv
// soc_trace_arbiter: merges per-core retire traces into one stream via one-entry slots and round-robin.
// Define SOC_TRACE_ARBITER_TIMESTAMP_EN to add a cycle-counter timestamp port (out_timestamp_o).
module soc_trace_arbiter
    import soc_trace_arbiter_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int DROP_CNT_W = 16,
    localparam int CORE_ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        trace_valid_i,
    input  logic [NUM_CORES*PC_W-1:0]   trace_pc_i,
    input  logic [NUM_CORES*INSN_W-1:0] trace_insn_i,
    input  logic [NUM_CORES-1:0]        trace_wben_i,
    input  logic [NUM_CORES*WBREG_W-1:0] trace_wbreg_i,
    input  logic [NUM_CORES*DATA_W-1:0] trace_wbdata_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [CORE_ID_W-1:0]        out_core_o,
    output logic [PC_W-1:0]             out_pc_o,
    output logic [INSN_W-1:0]           out_insn_o,
    output logic [DATA_W-1:0]           out_wbdata_o,
    output logic                        out_wben_o,
    output logic [WBREG_W-1:0]          out_wbreg_o,
    output logic [DROP_CNT_W-1:0]       drop_cnt_o
`ifdef SOC_TRACE_ARBITER_TIMESTAMP_EN
    ,output logic [TS_W-1:0]            out_timestamp_o
`endif
);
    trace_rec_t            r_slot [NUM_CORES];
    trace_rec_t            w_in   [NUM_CORES];
    trace_rec_t            r_out;
    logic [NUM_CORES-1:0]  r_full, w_arb_gnt, w_gnt, w_drop;
    logic [CORE_ID_W-1:0]  r_last, r_out_core, w_idx;
    logic                  r_out_valid, w_take;
    logic [CORE_ID_W:0]    w_ndrop;
    logic [DROP_CNT_W:0]   w_sum;
    logic [DROP_CNT_W-1:0] r_drop;
`ifdef SOC_TRACE_ARBITER_TIMESTAMP_EN
    logic [TS_W-1:0]       r_ts;
    always_ff @(posedge clk) begin
        r_ts <= rst ? '0 : r_ts + 1'b1;
    end
    assign out_timestamp_o = r_out.timestamp;
`endif

    soc_trace_rr_arbiter #(.N(NUM_CORES), .ID_W(CORE_ID_W)) u_rr (
        .i_req  (r_full),
        .i_last (r_last),
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_idx)
    );

    assign w_take = (|r_full) && (!r_out_valid || out_ready_i);
    assign w_gnt  = w_take ? w_arb_gnt : '0;
    // A slot granted this edge frees up in time to accept the new record.
    assign w_drop = trace_valid_i & r_full & ~w_gnt;
    assign w_sum  = {1'b0, r_drop} + (DROP_CNT_W+1)'(w_ndrop);

    always_comb begin
        w_ndrop = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_ndrop          = w_ndrop + (CORE_ID_W+1)'(w_drop[i]);
            w_in[i]          = '0;
            w_in[i].pc       = trace_pc_i[PC_W*i +: PC_W];
            w_in[i].insn     = trace_insn_i[INSN_W*i +: INSN_W];
            w_in[i].wben     = trace_wben_i[i];
            w_in[i].wbreg    = trace_wbreg_i[WBREG_W*i +: WBREG_W];
            w_in[i].wbdata   = trace_wbdata_i[DATA_W*i +: DATA_W];
`ifdef SOC_TRACE_ARBITER_TIMESTAMP_EN
            w_in[i].timestamp = r_ts;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full      <= '0;
            r_last      <= CORE_ID_W'(NUM_CORES - 1);
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_core  <= '0;
            r_drop      <= '0;
            for (int i = 0; i < NUM_CORES; i++) r_slot[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (trace_valid_i[i] && (!r_full[i] || w_gnt[i])) begin
                    r_full[i] <= 1'b1;
                    r_slot[i] <= w_in[i];
                end else if (w_gnt[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
            if (w_take) begin
                r_out_valid <= 1'b1;
                r_out       <= r_slot[w_idx];
                r_out_core  <= w_idx;
                r_last      <= w_idx;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
            r_drop <= w_sum[DROP_CNT_W] ? '1 : w_sum[DROP_CNT_W-1:0];
        end
    end

    assign out_valid_o  = r_out_valid;
    assign out_core_o   = r_out_core;
    assign out_pc_o     = r_out.pc;
    assign out_insn_o   = r_out.insn;
    assign out_wben_o   = r_out.wben;
    assign out_wbreg_o  = r_out.wbreg;
    assign out_wbdata_o = r_out.wbdata;
    assign drop_cnt_o   = r_drop;
endmodule
